// File: rtl/fir_mac_stream_if.sv
// Streaming valid/ready bundle for fir_mac_stream: sample input and filtered output channels.
interface fir_mac_stream_if #(
   parameter int DATA_W = 16
);
   logic                     in_valid;
   logic                     in_ready;
   logic signed [DATA_W-1:0] in_data;
   logic                     out_valid;
   logic                     out_ready;
   logic signed [DATA_W-1:0] out_data;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/fir_mac_stream.sv
// Time-multiplexed FIR: one MAC walks all taps per sample, then rounds/saturates to DATA_W.
// Optional runtime coefficient loading via `define FIR_COEF_LOAD_EN.
module fir_mac_stream #(
   parameter int DATA_W    = 16,
   parameter int COEF_W    = 8,
   parameter int TAPS      = 21,
   parameter int OUT_SHIFT = 0,
   parameter logic [TAPS*COEF_W-1:0] COEF_INIT =
      168'hEDEEF2F7FC_00040606_06050302_0100FFFF_FF000000
) (
   input  logic                     clk,
   input  logic                     rst_n,
   fir_mac_stream_if.slave          strm,
   output logic                     busy
`ifdef FIR_COEF_LOAD_EN
   ,
   input  logic                     coef_we,
   input  logic [$clog2(TAPS)-1:0]  coef_addr,
   input  logic signed [COEF_W-1:0] coef_data
`endif
);

   localparam int ACC_W = DATA_W + COEF_W + $clog2(TAPS);
   localparam int SUM_W = ACC_W + 1;
   localparam int TAP_W = $clog2(TAPS);
   localparam int IDX_W = $clog2(TAPS + 1);
   localparam int RND_SH = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;

   localparam logic signed [SUM_W-1:0] RND  = (OUT_SHIFT > 0) ? (SUM_W'(1) <<< RND_SH) : '0;
   localparam logic signed [SUM_W-1:0] MAXV = SUM_W'({1'b0, {(DATA_W-1){1'b1}}});
   localparam logic signed [SUM_W-1:0] MINV = -MAXV - SUM_W'(1);

   typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

   state_t                     state;
   logic signed [DATA_W-1:0]   x [TAPS];
   logic signed [COEF_W-1:0]   coef [TAPS];
   logic signed [ACC_W-1:0]    acc;
   logic [IDX_W-1:0]           idx;
   logic [TAP_W-1:0]           tap;
   logic signed [ACC_W-1:0]    prod;
   logic signed [SUM_W-1:0]    rnd_sum;
   logic signed [SUM_W-1:0]    shifted;
   logic signed [DATA_W-1:0]   sat_val;

`ifdef FIR_COEF_LOAD_EN
   // Writes landing on the accept edge are visible to that sample: tap 0 is first read one cycle later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < TAPS; i++)
            coef[i] <= COEF_INIT[(TAPS-1-i)*COEF_W +: COEF_W];
      end else if (coef_we && state == IDLE && 32'(coef_addr) < TAPS) begin
         coef[coef_addr] <= coef_data;
      end
   end
`else
   always_comb begin
      for (int unsigned i = 0; i < TAPS; i++)
         coef[i] = COEF_INIT[(TAPS-1-i)*COEF_W +: COEF_W];
   end
`endif

   always_comb begin
      tap     = (idx == IDX_W'(TAPS)) ? '0 : TAP_W'(idx);
      prod    = ACC_W'(x[tap]) * ACC_W'(coef[tap]);
      rnd_sum = SUM_W'(acc) + RND;
      shifted = rnd_sum >>> OUT_SHIFT;
      if (shifted > MAXV)
         sat_val = MAXV[DATA_W-1:0];
      else if (shifted < MINV)
         sat_val = MINV[DATA_W-1:0];
      else
         sat_val = shifted[DATA_W-1:0];
   end

   // idx runs one past the last tap so the final sum is registered before out_data is formed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         for (int unsigned i = 0; i < TAPS; i++)
            x[i] <= '0;
         acc           <= '0;
         idx           <= '0;
         strm.out_valid <= 1'b0;
         strm.out_data  <= '0;
         strm.in_ready  <= 1'b1;
         busy          <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (strm.in_valid && strm.in_ready) begin
                  x[0] <= strm.in_data;
                  for (int unsigned i = 1; i < TAPS; i++)
                     x[i] <= x[i-1];
                  acc           <= '0;
                  idx           <= '0;
                  strm.in_ready <= 1'b0;
                  busy          <= 1'b1;
                  state         <= MAC;
               end
            end
            MAC: begin
               if (idx == IDX_W'(TAPS)) begin
                  strm.out_data  <= sat_val;
                  strm.out_valid <= 1'b1;
                  state          <= OUT;
               end else begin
                  acc <= acc + prod;
                  idx <= idx + 1'b1;
               end
            end
            OUT: begin
               if (strm.out_ready) begin
                  strm.out_valid <= 1'b0;
                  strm.in_ready  <= 1'b1;
                  busy           <= 1'b0;
                  state          <= IDLE;
               end
            end
            default: begin
               state          <= IDLE;
               strm.out_valid <= 1'b0;
               strm.in_ready  <= 1'b1;
               busy           <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fir_mac_stream.sv
// Directed bench for fir_mac_stream: table of impulse/step vectors plus latency, saturation,
// backpressure, mid-MAC reset and (with FIR_COEF_LOAD_EN) coefficient-load sequences.
module tb_fir_mac_stream;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic busy;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   fir_mac_stream_if #(.DATA_W(16)) bus ();

`ifdef FIR_COEF_LOAD_EN
   logic              coef_we = 1'b0;
   logic [4:0]        coef_addr = '0;
   logic signed [7:0] coef_data = '0;
`endif

   fir_mac_stream #(.DATA_W(16), .COEF_W(8), .TAPS(21), .OUT_SHIFT(0)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .strm  (bus),
      .busy  (busy)
`ifdef FIR_COEF_LOAD_EN
      ,
      .coef_we   (coef_we),
      .coef_addr (coef_addr),
      .coef_data (coef_data)
`endif
   );

   typedef struct {
      logic signed [15:0] din;
      logic signed [15:0] dout;
   } vec_t;

   vec_t tbl[42];

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic push(input logic signed [15:0] d, output logic signed [15:0] y);
      int unsigned w;
      w = 0;
      while (!bus.in_ready && w < 100) begin
         @(posedge clk); #1; w++;
      end
      if (w >= 100) check("in_ready_timeout", 0, 1);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      w = 0;
      while (!bus.out_valid && w < 100) begin
         @(posedge clk); #1; w++;
      end
      if (w >= 100) check("out_valid_timeout", 0, 1);
      y = bus.out_data;
      if (bus.out_ready) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      int coefs[21] = '{-19,-18,-14,-9,-4,0,4,6,6,6,5,3,2,1,0,-1,-1,-1,0,0,0};
      int stepo[21] = '{19,37,51,60,64,64,60,54,48,42,37,34,32,31,31,32,33,34,34,34,34};
      logic signed [15:0] y;
      logic signed [15:0] held;
      int unsigned cyc;

      for (int i = 0; i < 21; i++) begin
         tbl[i].din       = (i == 0) ? 16'sd1 : 16'sd0;
         tbl[i].dout      = 16'(coefs[i]);
         tbl[21 + i].din  = -16'sd1;
         tbl[21 + i].dout = 16'(stepo[i]);
      end

      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
      do_reset();

      check("rst_out_valid", int'(bus.out_valid), 0);
      check("rst_out_data", int'(bus.out_data), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_in_ready", int'(bus.in_ready), 1);

      for (int i = 0; i < 42; i++) begin
         push(tbl[i].din, y);
         check((i < 21) ? "impulse" : "step", int'(y), int'(tbl[i].dout));
      end

      // Latency: accept edge is cycle 0, out_valid expected after edge 22.
      do_reset();
      bus.in_valid = 1'b1;
      bus.in_data  = 16'sd5;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      check("busy_in_mac", int'(busy), 1);
      cyc = 0;
      while (!bus.out_valid && cyc < 100) begin
         @(posedge clk); #1; cyc++;
      end
      check("latency", int'(cyc), 22);
      check("latency_data", int'(bus.out_data), -95);
      @(posedge clk); #1;

      do_reset();
      push(-16'sd32768, y);
      check("sat_pos", int'(y), 32767);
      do_reset();
      push(16'sd32767, y);
      check("sat_neg", int'(y), -32768);

      // Backpressure: output must hold while extra in_valid pulses are ignored.
      do_reset();
      bus.out_ready = 1'b0;
      push(16'sd1, y);
      check("bp_first", int'(y), -19);
      held = y;
      for (int i = 0; i < 10; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 16'sd1000;
         @(posedge clk); #1;
         check("bp_hold",
               int'({bus.out_valid, bus.in_ready, busy, (bus.out_data == held)}), 'b1011);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_release", int'({bus.out_valid, bus.in_ready}), 'b01);
      push(16'sd0, y);
      check("bp_not_queued", int'(y), -18);

      // Reset while idx is 10: output dropped, history cleared.
      do_reset();
      push(16'sd7, y);
      bus.in_valid = 1'b1;
      bus.in_data  = 16'sd300;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("midrst_out_valid", int'(bus.out_valid), 0);
      check("midrst_busy", int'(busy), 0);
      @(posedge clk); #1 rst_n = 1'b1;
      for (int i = 0; i < 21; i++) begin
         push(tbl[i].din, y);
         check("midrst_impulse", int'(y), int'(tbl[i].dout));
      end

`ifdef FIR_COEF_LOAD_EN
      do_reset();
      coef_we = 1'b1; coef_addr = 5'd0; coef_data = 8'sd5;
      @(posedge clk); #1;
      coef_we = 1'b0;
      push(16'sd1, y);
      check("load_idle", int'(y), 5);
      bus.in_valid = 1'b1;
      bus.in_data  = 16'sd0;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 coef_we = 1'b1; coef_addr = 5'd0; coef_data = 8'sd7;
      @(posedge clk); #1 coef_we = 1'b0;
      cyc = 0;
      while (!bus.out_valid && cyc < 100) begin
         @(posedge clk); #1; cyc++;
      end
      check("load_mac_sample", int'(bus.out_data), -18);
      @(posedge clk); #1;
      for (int i = 0; i < 20; i++) push(16'sd0, y);
      push(16'sd1, y);
      check("load_mac_ignored", int'(y), 5);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
